// File: rtl/display_pkg.sv
// Shared types and constants for the signed 7-segment display driver.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LATCH   = 2'd2
  } state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_UNITS = 2'd0;
  localparam logic [1:0] DIG_TENS  = 2'd1;
  localparam logic [1:0] DIG_SIGN  = 2'd2;

  // Double-dabble correction applied to each BCD nibble before the shift
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/display_c2_driver_seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment map; zero latency, no flow control.
// Codes above 9 show blank.
module seg7_decode (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  import display_pkg::*;

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_c2_driver.sv
// Signed value -> sign/tens/units scanned 7-seg display; done at WIDTH+1 cycles after accept,
// ready_out low while converting (no queueing). LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module display_c2_driver #(
  parameter int WIDTH       = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] value_in,
  output logic             ready_out,
  output logic             done,
  output logic [6:0]       seg,
  output logic [2:0]       an
);
  import display_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t            state, state_nxt;
  logic [CW-1:0]     iter;
  logic [WIDTH-1:0]  mag;
  logic              sgn;
  // Two BCD digits suffice for |value| <= 99, i.e. WIDTH up to 7
  logic [7:0]        bcd, bcd_adj;
  logic [7+WIDTH:0]  shifted;
  logic              disp_sgn;
  logic [3:0]        disp_tens, disp_units;
  logic [RW-1:0]     rcnt;
  logic [1:0]        scan;
  logic [3:0]        nib;
  logic [6:0]        dec_seg;
  logic              last_iter, wrap;

  assign last_iter = (iter == CW'(WIDTH - 1));
  assign bcd_adj   = {dd_adj(bcd[7:4]), dd_adj(bcd[3:0])};
  assign shifted   = {bcd_adj, mag} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_nxt = CONVERT;
      end
      CONVERT: if (last_iter) state_nxt = LATCH;
      LATCH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn        <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      iter       <= '0;
      disp_sgn   <= 1'b0;
      disp_tens  <= '0;
      disp_units <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          sgn  <= value_in[WIDTH-1];
          mag  <= value_in[WIDTH-1] ? (~value_in + 1'b1) : value_in;
          bcd  <= '0;
          iter <= '0;
        end
        CONVERT: begin
          bcd  <= shifted[7+WIDTH:WIDTH];
          mag  <= shifted[WIDTH-1:0];
          iter <= iter + 1'b1;
        end
        LATCH: begin
          disp_sgn   <= sgn;
          disp_tens  <= bcd[7:4];
          disp_units <= bcd[3:0];
        end
        default: ;
      endcase
    end
  end

  // Free-running digit scan, independent of the conversion FSM
  assign wrap = (rcnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcnt <= '0;
      scan <= DIG_UNITS;
    end else if (wrap) begin
      rcnt <= '0;
      scan <= (scan == DIG_SIGN) ? DIG_UNITS : scan + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    nib = disp_units;
    if (scan == DIG_TENS) nib = disp_tens;
  end

  seg7_decode u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  always_comb begin
    an  = 3'b110;
    seg = dec_seg;
    case (scan)
      DIG_TENS: begin
        an = 3'b101;
`ifdef LEADING_ZERO_BLANK_EN
        if (disp_tens == 4'd0) seg = SEG_BLANK;
`endif
      end
      DIG_SIGN: begin
        an  = 3'b011;
        seg = disp_sgn ? SEG_MINUS : SEG_BLANK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_display_c2_driver.sv
// Scoreboard bench for display_c2_driver with WIDTH=6, REFRESH_DIV=4.
module tb_display_c2_driver;

  typedef struct packed {
    logic [6:0] u;
    logic [6:0] t;
    logic [6:0] s;
  } digs_t;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [5:0] value_in = '0;
  logic       ready_out, done;
  logic [6:0] seg;
  logic [2:0] an;

  int n_tests = 0;
  int n_fail  = 0;
  digs_t sb[$];

  display_c2_driver #(.WIDTH(6), .REFRESH_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .value_in  (value_in),
    .ready_out (ready_out),
    .done      (done),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] segtab(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic digs_t model(input logic [5:0] v);
    digs_t r;
    int x, m;
    x = $signed(v);
    m = (x < 0) ? -x : x;
    r.u = segtab(m % 10);
    r.t = (LZB && (m / 10) == 0) ? 7'b1111111 : segtab(m / 10);
    r.s = (x < 0) ? 7'b0111111 : 7'b1111111;
    return r;
  endfunction

  // Sample 12 cycles (one full scan) and collect what each digit shows
  task automatic capture(output digs_t got, output int bad_an);
    got = '{u: 7'h55, t: 7'h55, s: 7'h55};
    bad_an = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      case (an)
        3'b110: got.u = seg;
        3'b101: got.t = seg;
        3'b011: got.s = seg;
        default: bad_an++;
      endcase
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", (n < 50), 1);
  endtask

  task automatic do_txn(input logic [5:0] v, input bit hold);
    int pulses, done_cyc, bad_an;
    digs_t exp_d, got;
    bit have_exp;
    wait_ready();
    valid_in = 1'b1;
    value_in = v;
    sb.push_back(model(v));
    @(posedge clk);
    @(negedge clk);
    if (hold) value_in = 6'b000001;
    else      valid_in = 1'b0;
    pulses = 0;
    done_cyc = -1;
    have_exp = 1'b0;
    exp_d = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 7) valid_in = 1'b0;
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc = c;
          if (sb.size() == 0) chk("sb_nonempty", 0, 1);
          else begin
            exp_d = sb.pop_front();
            have_exp = 1'b1;
          end
        end
      end
      if (c == 7) chk("ready_busy", ready_out, 0);
      if (c == 8) chk("ready_back", ready_out, 1);
    end
    chk("done_pulses", pulses, 1);
    chk("done_cycle", done_cyc, 7);
    if (have_exp) begin
      capture(got, bad_an);
      chk("an_onehot", bad_an, 0);
      chk("units", got.u, exp_d.u);
      chk("tens", got.t, exp_d.t);
      chk("sign", got.s, exp_d.s);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    digs_t got;
    int bad_an, pulses;
    logic [6:0] tens0;
    tens0 = LZB ? 7'b1111111 : 7'b1000000;

    repeat (3) @(negedge clk);
    chk("rst_ready", ready_out, 1);
    chk("rst_done", done, 0);
    chk("rst_an", an, 3'b110);
    chk("rst_seg", seg, 7'b1000000);

    // Scan order and dwell right after reset release
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      case ((k / 4) % 3)
        0: begin chk("scan_an_u", an, 3'b110); chk("scan_seg_u", seg, 7'b1000000); end
        1: begin chk("scan_an_t", an, 3'b101); chk("scan_seg_t", seg, tens0); end
        default: begin chk("scan_an_s", an, 3'b011); chk("scan_seg_s", seg, 7'b1111111); end
      endcase
      @(negedge clk);
    end

    do_txn(6'b000101, 1'b1);
    do_txn(6'b110011, 1'b0);
    do_txn(6'b100000, 1'b0);
    do_txn(6'b011111, 1'b0);
    do_txn(6'b111001, 1'b0);
    do_txn(6'b000000, 1'b0);
    do_txn(6'b111111, 1'b0);

    // Reset in the middle of a conversion of -13
    wait_ready();
    valid_in = 1'b1;
    value_in = 6'b110011;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready_out, 1);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_an", an, 3'b110);
    chk("mid_rst_seg", seg, 7'b1000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mid_rst_no_done", pulses, 0);
    capture(got, bad_an);
    chk("mid_rst_onehot", bad_an, 0);
    chk("mid_rst_units", got.u, 7'b1000000);
    chk("mid_rst_tens", got.t, tens0);
    chk("mid_rst_sign", got.s, 7'b1111111);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_c2_driver.md
Name: display_c2_driver

Overview:
- Consumes the signed two's-complement result of the 4-bit adder/subtractor (6-bit, range -32..+31) and shows it on three multiplexed 7-segment digits: sign, tens, units.
- Sequential pipeline:
  - valid/ready input handshake.
  - Iterative shift-add-3 (double-dabble) binary-to-BCD conversion.
  - Latched display registers.
  - Time-multiplexed refresh scan.
- Sits between the arithmetic datapath and the board's display pins.

Parameters:
- WIDTH, 6, width of the signed input value; conversion takes WIDTH cycles.
- REFRESH_DIV, 50000, clock cycles per digit in the scan; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  value_in is valid this cycle.
- value_in  in  WIDTH  signed two's-complement value to display.
- ready_out  out  1  block can accept a new value.
- done  out  1  one-cycle pulse when a new value is latched into the display.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  3  digit enables, active-low: an[0] units, an[1] tens, an[2] sign.

Behaviour:
- Reset values: ready_out=1, done=0, displayed value +0, scan index 0, refresh counter 0. Therefore an=3'b110 and seg=7'b1000000.
- Reset is honoured in any state, including mid-conversion: the conversion is aborted and the display returns to +0.
- FSM states: IDLE, CONVERT, LATCH.
- IDLE:
  - ready_out=1.
  - Accept when valid_in && ready_out on a rising edge.
  - On accept, register sign = value_in[WIDTH-1] and magnitude = sign ? (~value_in + 1) : value_in, as a WIDTH-bit unsigned value. -32 gives magnitude 32, no overflow.
  - Clear the BCD accumulator and the iteration counter, then go to CONVERT.
- CONVERT:
  - ready_out=0.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, magnitude} left by 1.
  - After exactly WIDTH iterations, go to LATCH.
- LATCH:
  - ready_out=0, done=1 for this single cycle.
  - Copy sign, tens and units into the display registers, then go to IDLE.
- Latency:
  - Accept edge at cycle 0; done is high during cycle WIDTH+1.
  - ready_out returns high in cycle WIDTH+2.
  - Throughput is one value per WIDTH+2 cycles.
- valid_in while ready_out=0 is ignored; there is no queueing.
- value_in is sampled only on the accept edge.
- The display keeps showing the previous latched value throughout CONVERT.
- Refresh:
  - The counter runs 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - On wrap, the scan index advances 0->1->2->0.
  - Exactly one an bit is low at all times.
  - seg and an are combinational from the scan index and display registers; no extra latency.
- Digit patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - minus=0111111, blank=1111111.
- Sign digit shows minus when negative, blank otherwise.
- Simultaneous LATCH and refresh wrap: the new value appears on the newly selected digit in the next cycle; no glitch requirement beyond that.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: the tens digit shows blank when tens==0 (e.g. -7 displays "- 7").
- Undefined: the tens digit always shows its numeral (e.g. "-07").
- The sign digit behaviour is unchanged either way.

Decomposition:
- Shared package display_pkg:
  - FSM state enum (IDLE, CONVERT, LATCH).
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK.
  - Scan index constants DIG_UNITS, DIG_TENS, DIG_SIGN.
- One natural sub-module: seg7_decode, a combinational BCD nibble to active-low segment map used by the output mux.

Test Plan (REFRESH_DIV=4, WIDTH=6):
- Assert rst then release -> ready_out=1, done=0, an=110, seg=1000000. The scan then cycles an 110->101->011 every 4 cycles, showing 0, 0 (or blank with LEADING_ZERO_BLANK_EN), blank.
- Accept value_in=6'b000101 (+5) -> done high exactly 7 cycles after the accept edge, ready_out high at 8. Digit outputs: units 0010010, tens 1000000, sign 1111111.
- Accept 6'b110011 (-13) -> units 0110000, tens 1111001, sign 0111111.
- Accept 6'b100000 (-32) -> units 0100100, tens 0110000, sign 0111111. Accept 6'b011111 (+31) -> units 1111001, tens 0110000, sign blank.
- Hold valid_in=1 with 6'b000001 during CONVERT of +5 -> the second value is not captured and exactly one done pulse occurs. Then assert rst at cycle 3 of a new conversion -> no done pulse; display and outputs return to reset values.
- With LEADING_ZERO_BLANK_EN, accept 6'b111001 (-7) -> units 1111000, tens 1111111, sign 0111111.
